// File: rtl/wb_sequencer.sv
// wb_sequencer: merges single-cycle ALU results and buffered LSU results onto
// the register file's single write port, and tracks outstanding slow
// destinations in a scoreboard so decode can stall on RAW/WAW hazards.
// Optional build macro WB_STATS_EN adds stall_cycles / alu_preempt counters.
module wb_sequencer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic            issue_slow,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            stall,
  output logic [31:0]     pending,
`ifdef WB_STATS_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     alu_preempt,
`endif
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] WriteData
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic        alu_wr, push, pop, sb_set;
  logic [4:0]  head_rd;
  logic [31:0] pending_nxt;

  // Port arbitration: ALU always wins; the FIFO head drains when the ALU is idle.
  // lsu_ready comes from the registered count, so a full FIFO refuses a push
  // even on a cycle where it pops.
  always_comb begin
    alu_wr    = alu_valid && (alu_rd != 5'd0);
    lsu_ready = (count < FULL);
    push      = lsu_valid && lsu_ready;
    pop       = !alu_wr && (count != '0);
    head_rd   = fifo_rd[rd_ptr];
    stall     = issue_valid && (((issue_rs1 != 5'd0) && pending[issue_rs1]) ||
                                ((issue_rs2 != 5'd0) && pending[issue_rs2]) ||
                                ((issue_rd  != 5'd0) && pending[issue_rd]));
    sb_set    = issue_valid && !stall && issue_slow && (issue_rd != 5'd0);
  end

  // Scoreboard next value: commit clears, issue sets, set wins on collision.
  always_comb begin
    pending_nxt = pending;
    if (pop && (head_rd != 5'd0)) pending_nxt[head_rd] = 1'b0;
    if (sb_set) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lsu_rd;
      fifo_data[wr_ptr] <= lsu_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered write port; rd/WriteData hold when nothing commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      rd        <= 5'd0;
      WriteData <= '0;
    end else if (alu_wr) begin
      RegWrite  <= 1'b1;
      rd        <= alu_rd;
      WriteData <= alu_data;
    end else if (pop && (head_rd != 5'd0)) begin
      RegWrite  <= 1'b1;
      rd        <= head_rd;
      WriteData <= fifo_data[rd_ptr];
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

`ifdef WB_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      alu_preempt  <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (alu_wr && (count != '0) && (alu_preempt != '1)) alu_preempt <= alu_preempt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Randomized bench for wb_sequencer with a queue-based reference model.
// Build with WB_STATS_EN defined to also cover the statistics counters.
module tb_wb_sequencer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, lsu_valid, lsu_ready;
  logic [4:0]      alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            issue_valid, issue_slow, stall;
  logic [4:0]      issue_rd, issue_rs1, issue_rs2;
  logic [31:0]     pending;
  logic            RegWrite;
  logic [4:0]      rd;
  logic [XLEN-1:0] WriteData;
`ifdef WB_STATS_EN
  logic [31:0]     stall_cycles, alu_preempt;
`endif

  wb_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_slow(issue_slow), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .stall(stall), .pending(pending),
`ifdef WB_STATS_EN
    .stall_cycles(stall_cycles), .alu_preempt(alu_preempt),
`endif
    .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] r; logic [XLEN-1:0] d; } entry_t;

  // reference model state
  entry_t          mq[$];
  bit              mpend [32];
  logic            exp_we;
  logic [4:0]      exp_rd;
  logic [XLEN-1:0] exp_wd;
  longint          m_stall_cnt, m_preempt_cnt;
  bit              last_push_ok;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mpend[i];
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mpend[i] = 0;
    exp_we = 0; exp_rd = 0; exp_wd = 0;
    m_stall_cnt = 0; m_preempt_cnt = 0;
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_slow = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask

  task automatic check_outputs();
    check_val("RegWrite", RegWrite, exp_we);
    check_val("rd", rd, exp_rd);
    check_val("WriteData", WriteData, exp_wd);
    check_val("pending", pending, pend_vec());
`ifdef WB_STATS_EN
    check_val("stall_cycles", stall_cycles, m_stall_cnt);
    check_val("alu_preempt", alu_preempt, m_preempt_cnt);
`endif
  endtask

  // One clock: check combinational outputs, predict the edge, check registered outputs.
  task automatic step();
    bit ready_m, stall_m, alu_w;
    entry_t e;
    #1;
    ready_m = (mq.size() < DEPTH);
    stall_m = issue_valid && ((issue_rs1 != 0 && mpend[issue_rs1]) ||
                              (issue_rs2 != 0 && mpend[issue_rs2]) ||
                              (issue_rd  != 0 && mpend[issue_rd]));
    check_val("lsu_ready", lsu_ready, ready_m);
    check_val("stall", stall, stall_m);
    alu_w = alu_valid && alu_rd != 0;
    if (stall_m && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
    if (alu_w) begin
      if (mq.size() > 0 && m_preempt_cnt < 64'hFFFF_FFFF) m_preempt_cnt++;
      exp_we = 1; exp_rd = alu_rd; exp_wd = alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.r != 0) begin
        exp_we = 1; exp_rd = e.r; exp_wd = e.d; mpend[e.r] = 0;
      end else exp_we = 0;
    end else exp_we = 0;
    last_push_ok = lsu_valid && ready_m;
    if (last_push_ok) begin
      e.r = lsu_rd; e.d = lsu_data; mq.push_back(e);
    end
    if (issue_valid && !stall_m && issue_slow && issue_rd != 0) mpend[issue_rd] = 1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    rst = 1;
    #1;
    model_reset();
    check_val("rst_RegWrite", RegWrite, 1'b0);
    check_val("rst_pending", pending, 32'd0);
    check_val("rst_lsu_ready", lsu_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold_RegWrite", RegWrite, 1'b0);
    check_val("rst_hold_lsu_ready", lsu_ready, 1'b1);
    rst = 0;
  endtask

  initial begin
    int pushed, id, guard;
    set_idle();
    model_reset();
    rst = 1;
    // reset with an ALU write held at the inputs
    alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
    #2;
    check_val("rst0_RegWrite", RegWrite, 1'b0);
    check_val("rst0_pending", pending, 32'd0);
    check_val("rst0_lsu_ready", lsu_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst1_RegWrite", RegWrite, 1'b0);
    rst = 0;
    step();
    check_val("first_alu_rd", rd, 5'd5);

    // ALU write then ALU to x0
    alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF; step();
    alu_rd = 0; alu_data = 32'h5555; step();
    check_val("x0_no_write", RegWrite, 1'b0);
    set_idle();

    // slow issue to x7, dependent issue stalls until the LSU commit
    issue_valid = 1; issue_slow = 1; issue_rd = 7; step();
    issue_slow = 0; issue_rd = 8; issue_rs1 = 7;
    step(); step();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234; step();
    lsu_valid = 0; step();
    check_val("x7_cleared", pending[7], 1'b0);
    step();
    set_idle();

    // fill while ALU busy, then drain in order
    for (int i = 1; i <= 5; i++) begin
      alu_valid = 1; alu_rd = 5'(20 + i); alu_data = $urandom;
      lsu_valid = 1; lsu_rd = 5'(i); lsu_data = 32'h100 + i;
      step();
    end
    set_idle();
    for (int i = 0; i < 5; i++) step();

    // full FIFO with simultaneous pop and push attempts, 12 pushes through wrap
    pushed = 0; id = 1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 30; alu_data = $urandom;
      lsu_valid = 1; lsu_rd = 5'(id); lsu_data = 32'hA000 + id;
      step();
      if (last_push_ok) begin pushed++; id++; end
    end
    alu_valid = 0;
    guard = 0;
    while (pushed < 12 && guard < 60) begin
      lsu_valid = 1; lsu_rd = 5'(id); lsu_data = 32'hA000 + id;
      step();
      if (last_push_ok) begin pushed++; id++; end
      guard++;
    end
    check_val("wrap_push_count", pushed, 12);
    set_idle();
    for (int i = 0; i < 6; i++) step();

    // mid-operation reset with 3 entries queued and pending[9] set
    issue_valid = 1; issue_slow = 1; issue_rd = 9;
    alu_valid = 1; alu_rd = 2; lsu_valid = 1; lsu_rd = 11; step();
    issue_valid = 0; lsu_rd = 12; step();
    lsu_rd = 13; step();
    set_idle();
    apply_reset();
    for (int i = 0; i < 3; i++) step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 1) == 1);
      lsu_rd      = 5'($urandom_range(0, 7));
      lsu_data    = $urandom;
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_slow  = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      step();
      if (n == 1500) begin
        set_idle();
        apply_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
